// File: rtl/noc_pkt_injector_if.sv
// ---------------------------------------------------------------------------
// noc_pkt_injector_if
//
// Bundles every per-channel handshake and bus signal of the packet injector
// so the injector and its environment connect through a single port.
//
// Signal summary (NCH channels, channel c occupies slice c of each vector):
//   desc_valid/desc_ready/desc_header/desc_size/desc_mode : descriptor input
//   pl_valid/pl_data/pl_ready                             : external payload
//   gap_cycles                                            : shared idle gap
//   rx/data_in/credit_o                                   : router port
//   busy/pkt_count                                        : channel status
//
// Modports:
//   master : the injector itself (drives router port, handshakes, status)
//   slave  : the environment feeding descriptors/payload and returning credit
// ---------------------------------------------------------------------------
interface noc_pkt_injector_if #(
    parameter int NCH        = 5,
    parameter int FLIT_WIDTH = 16,
    parameter int SIZE_WIDTH = 8,
    parameter int GAP_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
);
    logic [NCH-1:0]            desc_valid;
    logic [NCH-1:0]            desc_ready;
    logic [NCH*FLIT_WIDTH-1:0] desc_header;
    logic [NCH*SIZE_WIDTH-1:0] desc_size;
    logic [NCH-1:0]            desc_mode;
    logic [NCH-1:0]            pl_valid;
    logic [NCH*FLIT_WIDTH-1:0] pl_data;
    logic [NCH-1:0]            pl_ready;
    logic [GAP_WIDTH-1:0]      gap_cycles;
    logic [NCH-1:0]            rx;
    logic [NCH*FLIT_WIDTH-1:0] data_in;
    logic [NCH-1:0]            credit_o;
    logic [NCH-1:0]            busy;
    logic [NCH*CNT_WIDTH-1:0]  pkt_count;

    modport master (
        input  desc_valid, desc_header, desc_size, desc_mode,
        input  pl_valid, pl_data, gap_cycles, credit_o,
        output desc_ready, pl_ready, rx, data_in, busy, pkt_count
    );

    modport slave (
        output desc_valid, desc_header, desc_size, desc_mode,
        output pl_valid, pl_data, gap_cycles, credit_o,
        input  desc_ready, pl_ready, rx, data_in, busy, pkt_count
    );
endinterface

// File: rtl/noc_pkt_injector.sv
// ---------------------------------------------------------------------------
// noc_pkt_injector
//
// Multi-channel packet source. Each of NCH independent channels accepts a
// descriptor (header, payload size, payload mode), then drives its router
// port with header flit, size flit and payload flits under credit flow
// control. Payload comes either from an external stream (mode 0) or is
// generated as header+i+1 (mode 1). After each packet the channel idles for
// the gap latched at descriptor accept, and counts completed packets.
//
// Ports:
//   clock : rising-edge clock for all logic
//   reset : synchronous, active-high; returns every channel to IDLE
//   inj   : noc_pkt_injector_if.master bundle (descriptor, payload, router
//           port, busy and packet counters)
// ---------------------------------------------------------------------------
module noc_pkt_injector #(
    parameter int NCH        = 5,
    parameter int FLIT_WIDTH = 16,
    parameter int SIZE_WIDTH = 8,
    parameter int GAP_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic                 clock,
    input logic                 reset,
    noc_pkt_injector_if.master  inj
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_SIZE = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [FLIT_WIDTH-1:0] FLIT_ONE = {{(FLIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [2:0]            state;
        logic [FLIT_WIDTH-1:0] hdr_q;
        logic [SIZE_WIDTH-1:0] size_q;
        logic [SIZE_WIDTH-1:0] idx_q;
        logic                  mode_q;
        logic [GAP_WIDTH-1:0]  gap_q;
        logic [GAP_WIDTH-1:0]  gcnt_q;
        logic [CNT_WIDTH-1:0]  cnt_q;

        logic                  rx_c;
        logic                  pl_ready_c;
        logic [FLIT_WIDTH-1:0] data_c;
        logic                  xfer;
        logic                  last_pay;
        logic                  pkt_done;

        // Flit presented on the router port for the current state. In
        // external-payload mode the port simply mirrors the payload stream,
        // and the payload is consumed on the same edge the router takes it.
        always_comb begin
            rx_c       = 1'b0;
            data_c     = '0;
            pl_ready_c = 1'b0;
            case (state)
                S_HDR: begin
                    rx_c   = 1'b1;
                    data_c = hdr_q;
                end
                S_SIZE: begin
                    rx_c   = 1'b1;
                    data_c = FLIT_WIDTH'(size_q);
                end
                S_PAY: begin
                    if (mode_q) begin
                        rx_c   = 1'b1;
                        data_c = hdr_q + FLIT_WIDTH'(idx_q) + FLIT_ONE;
                    end else begin
                        rx_c       = inj.pl_valid[c];
                        data_c     = inj.pl_valid[c] ? inj.pl_data[c*FLIT_WIDTH +: FLIT_WIDTH] : '0;
                        pl_ready_c = inj.pl_valid[c] & inj.credit_o[c];
                    end
                end
                default: begin
                end
            endcase
        end

        // The last-payload test uses the latched size, which is nonzero
        // whenever PAY is entered, so size-1 never underflows.
        assign xfer     = rx_c & inj.credit_o[c];
        assign last_pay = (idx_q == (size_q - SIZE_ONE));
        assign pkt_done = xfer & (((state == S_SIZE) && (size_q == '0)) ||
                                  ((state == S_PAY) && last_pay));

        // Channel sequencer. Packet completion is handled ahead of the
        // per-state moves because it can come from either SIZE or PAY.
        always_ff @(posedge clock) begin
            if (reset) begin
                state  <= S_IDLE;
                hdr_q  <= '0;
                size_q <= '0;
                idx_q  <= '0;
                mode_q <= 1'b0;
                gap_q  <= '0;
                gcnt_q <= '0;
                cnt_q  <= '0;
            end else if (pkt_done) begin
                cnt_q <= cnt_q + CNT_ONE;
                if (gap_q == '0) begin
                    state <= S_IDLE;
                end else begin
                    gcnt_q <= gap_q;
                    state  <= S_GAP;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (inj.desc_valid[c]) begin
                            hdr_q  <= inj.desc_header[c*FLIT_WIDTH +: FLIT_WIDTH];
                            size_q <= inj.desc_size[c*SIZE_WIDTH +: SIZE_WIDTH];
                            mode_q <= inj.desc_mode[c];
                            gap_q  <= inj.gap_cycles;
                            idx_q  <= '0;
                            state  <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (xfer) begin
                            state <= S_SIZE;
                        end
                    end
                    S_SIZE: begin
                        if (xfer) begin
                            state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        if (xfer) begin
                            idx_q <= idx_q + SIZE_ONE;
                        end
                    end
                    S_GAP: begin
                        if (gcnt_q <= GAP_ONE) begin
                            state <= S_IDLE;
                        end else begin
                            gcnt_q <= gcnt_q - GAP_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end

        assign inj.rx[c]                                  = rx_c;
        assign inj.data_in[c*FLIT_WIDTH +: FLIT_WIDTH]    = data_c;
        assign inj.pl_ready[c]                            = pl_ready_c;
        assign inj.busy[c]                                = (state != S_IDLE);
        assign inj.desc_ready[c]                          = (state == S_IDLE);
        assign inj.pkt_count[c*CNT_WIDTH +: CNT_WIDTH]    = cnt_q;
    end

endmodule

// File: tb/tb_noc_pkt_injector.sv
// ---------------------------------------------------------------------------
// tb_noc_pkt_injector
//
// Self-checking bench for noc_pkt_injector. A cycle table covers the exact
// timing of single packets on channel 0; hand sequences cover stalls, reset
// mid-packet and counter wrap; a randomized phase drives all channels while
// a flit-stream reference model checks every transferred flit.
// ---------------------------------------------------------------------------
module tb_noc_pkt_injector;
    localparam int NCH = 5;
    localparam int FW  = 16;
    localparam int SW  = 8;
    localparam int GW  = 4;
    localparam int CW  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    noc_pkt_injector_if #(.NCH(NCH), .FLIT_WIDTH(FW), .SIZE_WIDTH(SW),
                          .GAP_WIDTH(GW), .CNT_WIDTH(CW)) bus ();

    noc_pkt_injector #(.NCH(NCH), .FLIT_WIDTH(FW), .SIZE_WIDTH(SW),
                       .GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .inj   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Expected flit stream per channel: what the router must see, in order.
    typedef struct {
        logic [FW-1:0] val;
        bit            ext;
        bit            last;
    } flit_t;

    flit_t         expQ [NCH][$];
    logic [CW-1:0] expCnt [NCH];
    int            plIdx [NCH];
    int            extEnq [NCH];
    int            pktAcc [NCH];

    bit monEn      = 1'b0;
    bit autoDrive  = 1'b0;
    bit randCredit = 1'b0;
    bit randPl     = 1'b0;
    bit randDesc   = 1'b0;
    int descLimit  = 0;

    typedef struct {
        logic          dv;
        logic [FW-1:0] hdr;
        logic [SW-1:0] size;
        logic          mode;
        logic [GW-1:0] gap;
        logic          credit;
        logic          expRx;
        logic [FW-1:0] expData;
        logic          expBusy;
        logic          expReady;
        logic [CW-1:0] expCnt;
    } vec_t;

    vec_t tbl [$];

    task automatic checkOutput(input string name, input int chan,
                               input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s ch%0d: got 0x%0h expected 0x%0h at %0t",
                     name, chan, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] extVal(input int c, input int n);
        return FW'(c * 4096 + n);
    endfunction

    function automatic void pushFlit(input int c, input logic [FW-1:0] v,
                                     input bit ext, input bit last);
        flit_t f;
        f.val  = v;
        f.ext  = ext;
        f.last = last;
        expQ[c].push_back(f);
    endfunction

    function automatic bit allEmpty();
        for (int c = 0; c < NCH; c++) begin
            if (expQ[c].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic vec_t mkVec(input logic dv, input logic [FW-1:0] hdr,
                                   input logic [SW-1:0] size, input logic mode,
                                   input logic [GW-1:0] gap, input logic credit,
                                   input logic eRx, input logic [FW-1:0] eData,
                                   input logic eBusy, input logic eReady,
                                   input logic [CW-1:0] eCnt);
        vec_t v;
        v.dv = dv; v.hdr = hdr; v.size = size; v.mode = mode; v.gap = gap;
        v.credit = credit; v.expRx = eRx; v.expData = eData; v.expBusy = eBusy;
        v.expReady = eReady; v.expCnt = eCnt;
        return v;
    endfunction

    task automatic clearModel();
        for (int c = 0; c < NCH; c++) begin
            expQ[c].delete();
            expCnt[c] = '0;
            plIdx[c]  = 0;
            extEnq[c] = 0;
            pktAcc[c] = 0;
        end
    endtask

    task automatic doReset();
        monEn      = 1'b0;
        autoDrive  = 1'b0;
        reset      = 1'b1;
        bus.desc_valid  = '0;
        bus.desc_header = '0;
        bus.desc_size   = '0;
        bus.desc_mode   = '0;
        bus.pl_valid    = '0;
        bus.pl_data     = '0;
        bus.gap_cycles  = '0;
        bus.credit_o    = '1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clearModel();
    endtask

    task automatic checkIdleAll(input string tag);
        for (int c = 0; c < NCH; c++) begin
            checkOutput({tag, "Rx"}, c, 32'(bus.rx[c]), 0);
            checkOutput({tag, "Data"}, c, 32'(bus.data_in[c*FW +: FW]), 0);
            checkOutput({tag, "PlReady"}, c, 32'(bus.pl_ready[c]), 0);
            checkOutput({tag, "Busy"}, c, 32'(bus.busy[c]), 0);
            checkOutput({tag, "DescReady"}, c, 32'(bus.desc_ready[c]), 1);
            checkOutput({tag, "Count"}, c, 32'(bus.pkt_count[c*CW +: CW]), 0);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.desc_valid[0]       = v.dv;
        bus.desc_header[FW-1:0] = v.hdr;
        bus.desc_size[SW-1:0]   = v.size;
        bus.desc_mode[0]        = v.mode;
        bus.gap_cycles          = v.gap;
        bus.credit_o[0]         = v.credit;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (n < maxCycles && !(allEmpty() && bus.busy == '0)) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= maxCycles) begin
            total++;
            bad++;
            $display("[TB] FAIL drainTimeout: still busy=0x%0h after %0d cycles, required idle",
                     bus.busy, maxCycles);
        end
    endtask

    // Reference model: on every transfer the flit must match the head of
    // the channel's expected stream; accepted descriptors expand into the
    // full header/size/payload stream they imply.
    always @(negedge clock) begin
        if (monEn && !reset) begin
            for (int c = 0; c < NCH; c++) begin
                logic          rxb;
                logic          cr;
                logic          pend;
                logic          extNext;
                logic [FW-1:0] d;
                logic [FW-1:0] hdr;
                int            sz;
                flit_t         f;
                rxb     = bus.rx[c];
                cr      = bus.credit_o[c];
                d       = bus.data_in[c*FW +: FW];
                pend    = (expQ[c].size() != 0);
                extNext = pend && expQ[c][0].ext;
                if (!rxb) checkOutput("dataZeroWhenIdle", c, 32'(d), 0);
                checkOutput("pktCount", c, 32'(bus.pkt_count[c*CW +: CW]), 32'(expCnt[c]));
                checkOutput("plReady", c, 32'(bus.pl_ready[c]),
                            32'(extNext & bus.pl_valid[c] & cr));
                if (pend) begin
                    checkOutput("busyInPacket", c, 32'(bus.busy[c]), 1);
                    checkOutput("descReadyInPacket", c, 32'(bus.desc_ready[c]), 0);
                    checkOutput("rxInPacket", c, 32'(rxb),
                                extNext ? 32'(bus.pl_valid[c]) : 32'd1);
                end
                if (rxb && cr) begin
                    if (pend) begin
                        f = expQ[c].pop_front();
                        checkOutput("flitValue", c, 32'(d), 32'(f.val));
                        if (f.last) expCnt[c] = expCnt[c] + 1'b1;
                    end else begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpectedFlit ch%0d: got 0x%0h expected no flit at %0t",
                                 c, d, $time);
                    end
                end
                if (bus.pl_ready[c]) plIdx[c]++;
                if (bus.desc_valid[c] && bus.desc_ready[c]) begin
                    hdr = bus.desc_header[c*FW +: FW];
                    sz  = int'(bus.desc_size[c*SW +: SW]);
                    pushFlit(c, hdr, 1'b0, 1'b0);
                    pushFlit(c, FW'(sz), 1'b0, sz == 0);
                    for (int k = 0; k < sz; k++) begin
                        if (bus.desc_mode[c]) begin
                            pushFlit(c, FW'(int'(hdr) + k + 1), 1'b0, k == sz - 1);
                        end else begin
                            pushFlit(c, extVal(c, extEnq[c]), 1'b1, k == sz - 1);
                            extEnq[c]++;
                        end
                    end
                    pktAcc[c]++;
                end
            end
        end
    end

    // Background driver for randomized phases: credit, payload stream and
    // (optionally) descriptors on every channel.
    always @(posedge clock) begin
        #1;
        if (autoDrive) begin
            for (int c = 0; c < NCH; c++) begin
                bus.credit_o[c]         = randCredit ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.pl_valid[c]         = randPl ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.pl_data[c*FW +: FW] = extVal(c, plIdx[c]);
                if (randDesc) begin
                    if (pktAcc[c] < descLimit) begin
                        bus.desc_valid[c]          = ($urandom_range(0, 2) != 0);
                        bus.desc_header[c*FW +: FW] = FW'($urandom);
                        bus.desc_size[c*SW +: SW]  = ($urandom_range(0, 15) == 0) ?
                                                     SW'(255) : SW'($urandom_range(0, 6));
                        bus.desc_mode[c]           = 1'($urandom_range(0, 1));
                    end else begin
                        bus.desc_valid[c] = 1'b0;
                    end
                end
            end
            if (randDesc) bus.gap_cycles = GW'($urandom_range(0, 3));
        end
    end

    initial begin
        logic [15:0] crPat;
        logic [15:0] pvPat;
        int          n;

        doReset();
        checkIdleAll("reset");

        // Channel 0 cycle table: generated payload, header wrap, a credit
        // stall, ignored descriptor while busy, size 0 with gap 3, and
        // back-to-back packets at gap 0.
        tbl.push_back(mkVec(1, 16'h0012, 3, 1, 0, 1,  0, 16'h0000, 0, 1, 0));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0012, 1, 0, 0));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0003, 1, 0, 0));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0013, 1, 0, 0));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0014, 1, 0, 0));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0015, 1, 0, 0));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  0, 16'h0000, 0, 1, 1));
        tbl.push_back(mkVec(1, 16'hFFFE, 3, 1, 0, 1,  0, 16'h0000, 0, 1, 1));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'hFFFE, 1, 0, 1));
        tbl.push_back(mkVec(1, 16'h7777, 9, 0, 5, 0,  1, 16'h0003, 1, 0, 1));
        tbl.push_back(mkVec(1, 16'h7777, 9, 0, 5, 1,  1, 16'h0003, 1, 0, 1));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'hFFFF, 1, 0, 1));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0000, 1, 0, 1));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0001, 1, 0, 1));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  0, 16'h0000, 0, 1, 2));
        tbl.push_back(mkVec(1, 16'h0AB0, 0, 1, 3, 1,  0, 16'h0000, 0, 1, 2));
        tbl.push_back(mkVec(1, 16'h0BB0, 0, 1, 0, 1,  1, 16'h0AB0, 1, 0, 2));
        tbl.push_back(mkVec(1, 16'h0BB0, 0, 1, 0, 1,  1, 16'h0000, 1, 0, 2));
        tbl.push_back(mkVec(1, 16'h0BB0, 0, 1, 0, 1,  0, 16'h0000, 1, 0, 3));
        tbl.push_back(mkVec(1, 16'h0BB0, 0, 1, 0, 1,  0, 16'h0000, 1, 0, 3));
        tbl.push_back(mkVec(1, 16'h0BB0, 0, 1, 0, 1,  0, 16'h0000, 1, 0, 3));
        tbl.push_back(mkVec(1, 16'h0BB0, 0, 1, 0, 1,  0, 16'h0000, 0, 1, 3));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0BB0, 1, 0, 3));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0000, 1, 0, 3));
        tbl.push_back(mkVec(1, 16'h0CC0, 0, 1, 0, 1,  0, 16'h0000, 0, 1, 4));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0CC0, 1, 0, 4));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  1, 16'h0000, 1, 0, 4));
        tbl.push_back(mkVec(0, 16'h0000, 0, 0, 0, 1,  0, 16'h0000, 0, 1, 5));

        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k]);
            #1;
            checkOutput($sformatf("tblRx[%0d]", k), 0, 32'(bus.rx[0]), 32'(tbl[k].expRx));
            checkOutput($sformatf("tblData[%0d]", k), 0, 32'(bus.data_in[FW-1:0]), 32'(tbl[k].expData));
            checkOutput($sformatf("tblBusy[%0d]", k), 0, 32'(bus.busy[0]), 32'(tbl[k].expBusy));
            checkOutput($sformatf("tblReady[%0d]", k), 0, 32'(bus.desc_ready[0]), 32'(tbl[k].expReady));
            checkOutput($sformatf("tblCount[%0d]", k), 0, 32'(bus.pkt_count[CW-1:0]), 32'(tbl[k].expCnt));
            @(posedge clock);
            #1;
        end

        // Channel 2 external payload with credit stall and gapped pl_valid.
        doReset();
        monEn = 1'b1;
        crPat = 16'hFFC7;
        pvPat = 16'hFFBB;
        bus.desc_valid[2]         = 1'b1;
        bus.desc_header[2*FW +: FW] = 16'h2200;
        bus.desc_size[2*SW +: SW] = 8'd4;
        bus.desc_mode[2]          = 1'b0;
        bus.pl_data[2*FW +: FW]   = extVal(2, 0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clock);
            #1;
            bus.desc_valid[2]       = 1'b0;
            bus.credit_o[2]         = crPat[k];
            bus.pl_valid[2]         = pvPat[k];
            bus.pl_data[2*FW +: FW] = extVal(2, plIdx[2]);
        end
        checkOutput("extQueueEmpty", 2, 32'(expQ[2].size()), 0);
        checkOutput("extPlReadyPulses", 2, 32'(plIdx[2]), 4);
        checkOutput("extCount", 2, 32'(bus.pkt_count[2*CW +: CW]), 1);
        checkOutput("extBusyAfter", 2, 32'(bus.busy[2]), 0);

        // Reset during the second payload flit of a 6-payload packet.
        doReset();
        bus.desc_valid[1]           = 1'b1;
        bus.desc_header[1*FW +: FW] = 16'h0100;
        bus.desc_size[1*SW +: SW]   = 8'd6;
        bus.desc_mode[1]            = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            bus.desc_valid[1] = 1'b0;
        end
        #1;
        checkOutput("preResetFlit", 1, 32'(bus.data_in[1*FW +: FW]), 32'h0102);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkIdleAll("midReset");
        clearModel();
        monEn = 1'b1;
        bus.desc_valid[1]           = 1'b1;
        bus.desc_header[1*FW +: FW] = 16'h0200;
        @(posedge clock);
        #1;
        bus.desc_valid[1] = 1'b0;
        waitDrain(60);
        checkOutput("afterResetCount", 1, 32'(bus.pkt_count[1*CW +: CW]), 1);

        // All channels, generated payload of sizes 1..5, random credit.
        doReset();
        monEn      = 1'b1;
        randCredit = 1'b1;
        randPl     = 1'b1;
        randDesc   = 1'b0;
        autoDrive  = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            bus.desc_valid[c]           = 1'b1;
            bus.desc_header[c*FW +: FW] = FW'(c * 16'h1000 + 16'h0010);
            bus.desc_size[c*SW +: SW]   = SW'(c + 1);
            bus.desc_mode[c]            = 1'b1;
        end
        @(posedge clock);
        #2;
        bus.desc_valid = '0;
        waitDrain(200);
        for (int c = 0; c < NCH; c++) begin
            checkOutput("multiCount", c, 32'(bus.pkt_count[c*CW +: CW]), 1);
        end

        // Packet counter wrap on channel 3: 2^CW zero-size packets.
        doReset();
        monEn = 1'b1;
        bus.desc_valid[3]           = 1'b1;
        bus.desc_header[3*FW +: FW] = 16'h3000;
        bus.desc_size[3*SW +: SW]   = 8'd0;
        bus.desc_mode[3]            = 1'b1;
        n = 0;
        while (pktAcc[3] < (1 << CW) && n < 1500) begin
            @(posedge clock);
            #1;
            n++;
        end
        bus.desc_valid[3] = 1'b0;
        if (n >= 1500) begin
            total++;
            bad++;
            $display("[TB] FAIL wrapTimeout: accepted %0d packets, required %0d", pktAcc[3], 1 << CW);
        end
        waitDrain(20);
        checkOutput("wrapCount", 3, 32'(bus.pkt_count[3*CW +: CW]), 0);

        // Randomized traffic on every channel.
        doReset();
        monEn      = 1'b1;
        descLimit  = 25;
        randCredit = 1'b1;
        randPl     = 1'b1;
        randDesc   = 1'b1;
        autoDrive  = 1'b1;
        n = 0;
        while (n < 30000) begin
            bit doneAll;
            doneAll = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (pktAcc[c] < descLimit) doneAll = 1'b0;
            end
            if (doneAll) break;
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 30000) begin
            total++;
            bad++;
            $display("[TB] FAIL randomTimeout: descriptors not all accepted, required %0d per channel", descLimit);
        end
        randDesc = 1'b0;
        @(posedge clock);
        #2;
        bus.desc_valid = '0;
        waitDrain(5000);
        autoDrive = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            checkOutput("randCount", c, 32'(bus.pkt_count[c*CW +: CW]), 25);
        end

        monEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
